// File: rtl/sevenseg_scan_ctrl.sv
// rtl/sevenseg_scan_ctrl.sv - time-multiplexed N-digit seven-segment scan driver
// Frame-synchronous shadow capture, leading-zero suppression, blanking, dp and PWM brightness.
module sevenseg_scan_ctrl #(
    parameter int N_DIGITS   = 8,
    parameter int PRESCALE   = 100000,
    parameter int DUTY_W     = 3,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic [N_DIGITS-1:0]   blank_i,
    input  logic                  lz_en,
    input  logic [DUTY_W-1:0]     bright,
    output logic [N_DIGITS-1:0]   an_1,
    output logic [6:0]            segs_1,
    output logic                  dp_1,
    output logic                  frame_tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(N_DIGITS);
    localparam int SLICE = PRESCALE >> DUTY_W;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);
    localparam logic INV = (ACTIVE_LOW != 0);

    logic [PW-1:0]           pre_cnt;
    logic [IW-1:0]           idx;
    logic [4*N_DIGITS-1:0]   sh_digits;
    logic [N_DIGITS-1:0]     sh_dp;
    logic [N_DIGITS-1:0]     sh_blank;
    logic                    sh_lz;
    logic [DUTY_W-1:0]       sh_bright;

    logic                    frame_start;
    logic [4*N_DIGITS-1:0]   cur_digits;
    logic [N_DIGITS-1:0]     cur_dp;
    logic [N_DIGITS-1:0]     cur_blank;
    logic                    cur_lz;
    logic [DUTY_W-1:0]       cur_bright;

    logic [N_DIGITS-1:0]     sup;
    logic                    zero_run;
    logic [3:0]              sel_val;
    logic                    sel_dark;
    logic                    sel_dp;
    logic                    pwm_on;
    logic [N_DIGITS-1:0]     an_h;
    logic [6:0]              seg_h;
    logic                    dp_h;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign frame_start = (pre_cnt == '0) && (idx == '0);

    // At frame start the outputs must already show the freshly captured frame,
    // so the capture values bypass the shadow registers for that one cycle.
    always_comb begin
        cur_digits = frame_start ? digits_i : sh_digits;
        cur_dp     = frame_start ? dp_i     : sh_dp;
        cur_blank  = frame_start ? blank_i  : sh_blank;
        cur_lz     = frame_start ? lz_en    : sh_lz;
        cur_bright = frame_start ? bright   : sh_bright;
    end

    always_comb begin
        sup      = '0;
        zero_run = cur_lz;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            if (cur_digits[4*k +: 4] != 4'h0) begin
                zero_run = 1'b0;
            end
            sup[k] = zero_run && (k != 0);
        end
    end

    always_comb begin
        sel_val  = 4'h0;
        sel_dark = 1'b0;
        sel_dp   = 1'b0;
        an_h     = '0;
        pwm_on   = (32'(pre_cnt) < (32'(cur_bright) + 32'd1) * 32'(SLICE));
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                sel_val  = cur_digits[4*k +: 4];
                sel_dark = cur_blank[k] | sup[k];
                sel_dp   = cur_dp[k];
            end
            an_h[k] = pwm_on && (idx == IW'(k));
        end
        seg_h = sel_dark ? 7'h00 : hex7(sel_val);
        dp_h  = pwm_on && !sel_dark && sel_dp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt    <= '0;
            idx        <= '0;
            sh_digits  <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            sh_lz      <= 1'b0;
            sh_bright  <= '0;
            an_1       <= {N_DIGITS{INV}};
            segs_1     <= {7{INV}};
            dp_1       <= INV;
            frame_tick <= 1'b0;
        end else begin
            if (frame_start) begin
                sh_digits <= digits_i;
                sh_dp     <= dp_i;
                sh_blank  <= blank_i;
                sh_lz     <= lz_en;
                sh_bright <= bright;
            end
            if (pre_cnt == PRE_MAX) begin
                pre_cnt <= '0;
                idx     <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
            an_1       <= an_h ^ {N_DIGITS{INV}};
            segs_1     <= seg_h ^ {7{INV}};
            dp_1       <= dp_h ^ INV;
            frame_tick <= frame_start;
        end
    end

endmodule
